odd_parity_frame_checker: RTL and testbench

//  Serial receive-side stage placed downstream of the 3-input odd parity generator.

---
 rtl/odd_parity_pkg.sv | 22 ++
 rtl/odd_parity_frame_checker_sat_counter.sv | 40 ++++
 rtl/odd_parity_frame_checker.sv | 120 ++++++++++++
 tb/tb_odd_parity_frame_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity generator and frame checker stages:
// default data width, receive FSM states and the odd-parity helper.
package odd_parity_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int PAR_MAX_W  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Returns 1 when the word holds an even number of ones (i.e. odd parity violated
    // when applied to data+parity, or the parity bit to append when applied to data).
    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic odd_par(input logic [PAR_MAX_W-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/odd_parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] count
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [ERR_CNT_W-1:0] count_r;
    logic [ERR_CNT_W-1:0] count_s;

    // Next count: clear wins, then increment unless already saturated.
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = {ERR_CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_s = count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {ERR_CNT_W{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/odd_parity_frame_checker.sv
// Receive-side deserialiser for start/data(LSB first)/parity/stop frames; checks odd
// parity and the stop bit, and keeps a saturating count of bad frames.
module odd_parity_frame_checker
    import odd_parity_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 err_clr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state_r, state_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic              par_r, par_s;
    logic              done_s;
    logic              par_bad_s;
    logic              stop_bad_s;
    logic              err_inc_s;

    // Next-state logic; nothing advances on cycles without a bit strobe.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        par_s     = par_r;
        done_s    = 1'b0;
        if (bit_valid) begin
            case (state_r)
                IDLE: begin
                    if (!serial_in) begin
                        state_s   = DATA;
                        bit_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s[bit_cnt_r] = serial_in;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = PARITY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                PARITY: begin
                    par_s   = serial_in;
                    state_s = STOP;
                end
                STOP: begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame verdict, evaluated against the stop bit currently on the line.
    always_comb begin
        par_bad_s  = odd_par(PAR_MAX_W'({shift_r, par_r}));
        stop_bad_s = ~serial_in;
        err_inc_s  = done_s & (par_bad_s | stop_bad_s);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            par_r      <= 1'b0;
            data_out   <= {DATA_W{1'b0}};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            par_r      <= par_s;
            data_valid <= done_s;
            busy       <= (state_s != IDLE);
            if (done_s) begin
                data_out   <= shift_r;
                parity_err <= par_bad_s;
                frame_err  <= stop_bad_s;
            end
        end
    end

    sat_counter #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc_s),
        .clr   (err_clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Self-checking bench for odd_parity_frame_checker: directed scenarios plus random
// frames compared against a bit-counting reference model.
module tb_odd_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       serial_in;
    logic       err_clr;
    logic [2:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [3:0] err_count;

    int checks   = 0;
    int failures = 0;
    int model_err = 0;

    odd_parity_frame_checker #(.DATA_W(3), .ERR_CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b1;
    endtask

    // Up to max_gap idle cycles with a noisy line; the checker must stay busy.
    task automatic gap(input int max_gap, input string tag);
        int n;
        n = $urandom_range(max_gap, 0);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b0;
            serial_in = 1'($urandom);
            tick();
            check_eq({tag, "_busy_gap"}, 32'(busy), 32'd1);
        end
        serial_in = 1'b1;
    endtask

    // Sends one frame and checks the delivered result against the model.
    task automatic send_frame(input logic [2:0] data, input logic par, input logic stop,
                              input int max_gap, input logic clr, input string tag);
        logic exp_pe;
        logic exp_fe;
        exp_pe = (($countones({data, par}) % 2) == 0);
        exp_fe = ~stop;
        strobe(1'b0);
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            gap(max_gap, tag);
            strobe(data[i]);
        end
        gap(max_gap, tag);
        strobe(par);
        gap(max_gap, tag);
        err_clr = clr;
        strobe(stop);
        err_clr = 1'b0;
        if (clr) model_err = 0;
        else if ((exp_pe || exp_fe) && model_err < 15) model_err++;
        check_eq({tag, "_valid"}, 32'(data_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(data_out), 32'(data));
        check_eq({tag, "_perr"}, 32'(parity_err), 32'(exp_pe));
        check_eq({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
        check_eq({tag, "_errcnt"}, 32'(err_count), 32'(model_err));
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // One quiet cycle after a frame: pulse gone, results held.
    task automatic check_hold(input logic [2:0] data, input string tag);
        tick();
        check_eq({tag, "_pulse_gone"}, 32'(data_valid), 32'd0);
        check_eq({tag, "_data_hold"}, 32'(data_out), 32'(data));
    endtask

    initial begin
        logic [2:0] d;
        logic       p;
        logic       s;
        rst       = 1'b1;
        bit_valid = 1'b0;
        serial_in = 1'b1;
        err_clr   = 1'b0;
        tick();
        tick();
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_perr", 32'(parity_err), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick();

        // Idle line strobes must not start a frame.
        strobe(1'b1);
        strobe(1'b1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        send_frame(3'b101, 1'b1, 1'b1, 0, 1'b0, "good");
        check_hold(3'b101, "good");
        send_frame(3'b011, 1'b0, 1'b1, 0, 1'b0, "perr");
        check_hold(3'b011, "perr");
        send_frame(3'b000, 1'b1, 1'b0, 0, 1'b0, "ferr");
        send_frame(3'b110, 1'b1, 1'b1, 0, 1'b0, "after_ferr");
        send_frame(3'b111, 1'b0, 1'b1, 4, 1'b0, "gapped");
        check_hold(3'b111, "gapped");

        // Reset while the checker waits for the parity bit.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        rst       = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b1;
        tick();
        rst       = 1'b0;
        bit_valid = 1'b0;
        model_err = 0;
        check_eq("midrst_valid", 32'(data_valid), 32'd0);
        check_eq("midrst_data", 32'(data_out), 32'd0);
        check_eq("midrst_perr", 32'(parity_err), 32'd0);
        check_eq("midrst_ferr", 32'(frame_err), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_errcnt", 32'(err_count), 32'd0);
        strobe(1'b1);
        check_eq("midrst_no_pulse", 32'(data_valid), 32'd0);
        send_frame(3'b010, 1'b0, 1'b1, 1, 1'b0, "after_rst");

        // Saturation, then clear colliding with an increment.
        for (int i = 0; i < 20; i++) begin
            send_frame(3'(i), ~^(3'(i)) ^ 1'b1, 1'b1, 0, 1'b0, "sat");
        end
        check_eq("sat_final", 32'(err_count), 32'd15);
        send_frame(3'b001, 1'b1, 1'b1, 0, 1'b1, "clr_collide");
        send_frame(3'b100, 1'b1, 1'b0, 0, 1'b0, "post_clr");

        // Random frames, random idle time including back-to-back.
        for (int n = 0; n < 60; n++) begin
            d = 3'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(3, 0) != 0);
            for (int k = $urandom_range(2, 0); k > 0; k--) begin
                strobe(1'b1);
            end
            send_frame(d, p, s, $urandom_range(2, 0), ($urandom_range(9, 0) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
